csr_trap_unit: RTL and testbench
================================

CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 Parameter MTVEC_RESET, 32'h0000_0000: reset value of mtvec.
REQ-002 Parameter HART_ID, 0: value returned by mhartid (0xF14).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 instr_valid  in  1  decoded instruction retires this cycle.
REQ-006 instr_pc  in  32  PC of that instruction.
REQ-007 csr_op  in  2  Common::csr_op: 0 none, 1 write, 2 set, 3 clear.
REQ-008 csr_source  in  1  0: operand is rs1_data; 1: operand is zero-extended uimm.
REQ-009 csr_addr  in  12  CSR address; rs1_data  in  32; uimm  in  5.
REQ-010 exc_request  in  1, exc_cause  in  32  synchronous exception and its cause.
REQ-011 exc_ret  in  1  MRET; wfi  in  1  WFI.
REQ-012 irq_timer  in  1, irq_ext  in  1  level interrupt requests, synchronous to clk.
REQ-013 csr_rdata  out  32  old CSR value, combinational.
REQ-014 illegal_csr  out  1  unimplemented address, or write to read-only CSR.
REQ-015 trap_taken  out  1  PC must go to trap_vector this cycle.
REQ-016 trap_vector  out  32  mtvec; mepc_out  out  32  MRET target.
REQ-017 stall  out  1  core held, WFI state.

Function
REQ-018 CSRs: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mvendorid 0xF11, mhartid 0xF14.
REQ-019 Writable mstatus bits: MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; other bits read 0.
REQ-020 mie bits: MTIE[7], MEIE[11]; mip MTIP[7]/MEIP[11] are irq_timer/irq_ext registered once; mip is read-only.
REQ-021 mtvec[1:0] and mepc[1:0] are forced to 0 on write.
REQ-022 New value: op1 = operand; op2 = old|operand; op3 = old&~operand; committed at the clock edge when instr_valid.
REQ-023 op2/op3 with operand 0 do not write, and do not flag read-only CSRs.
REQ-024 Illegal address: csr_rdata=0, illegal_csr=1, no state change.
REQ-025 Interrupt pending = mstatus.MIE & |(mip&mie); sampled when instr_valid.
REQ-026 Interrupt priority: external (cause 0x8000_000B) over timer (0x8000_0007).
REQ-027 A pending interrupt preempts that instruction's exception, CSR write and MRET.
REQ-028 Trap entry, one cycle, trap_taken=1: mepc<=instr_pc, mcause<=cause, MPIE<=MIE, MIE<=0.
REQ-029 exc_request with no interrupt pending uses cause exc_cause; its CSR write is suppressed.
REQ-030 MRET without trap: MIE<=MPIE, MPIE<=1; mepc_out valid same cycle.
REQ-031 FSM RUN/WFI: RUN->WFI on instr_valid&wfi with no trap; in WFI stall=1.
REQ-032 WFI->RUN when |(mip&mie), independent of MIE; interrupt taken on next instr_valid if MIE=1.
REQ-033 instr_valid=0: no CSR write, no trap, trap_taken=0.

Reset
REQ-034 On rst: mstatus=0x0000_1800, mie=0, mip=0, mscratch=0, mepc=0, mcause=0, mtvec=MTVEC_RESET, counters 0, FSM RUN.
REQ-035 On rst all outputs are 0, except trap_vector=MTVEC_RESET.
REQ-036 rst asserted in WFI returns the FSM to RUN with stall=0.

Configuration
REQ-037 Macro CSR_COUNTERS_EN gates the counters.
REQ-038 With CSR_COUNTERS_EN: 64-bit mcycle (0xB00/0xB80) increments every cycle.
REQ-039 With CSR_COUNTERS_EN: 64-bit minstret (0xB02/0xB82) increments on instr_valid without trap.
REQ-040 Counters wrap 2^64-1 -> 0; a CSR write beats that cycle's increment.
REQ-041 Without CSR_COUNTERS_EN: those four addresses are illegal.

Structure
REQ-042 Package Common holds: CSR address constants, csr_op enum, cause constants, mstatus/mie bit-index constants.
REQ-043 Sub-module csr_counter64: 64-bit counter with inc, wr_lo/wr_hi, wdata; instantiated twice under CSR_COUNTERS_EN.

Verification
REQ-044 CSRRW 0x305 rs1=0x8000_0103 -> mtvec reads 0x8000_0100; csr_rdata showed old value.
REQ-045 mie=0x800, MIE=1, irq_ext=1 (registered), instr_valid pc=0x40 -> trap_taken=1, mepc=0x40, mcause=0x8000_000B, MIE=0, MPIE=1.
REQ-046 Interrupt and exc_request(cause 2) same cycle -> mcause interrupt cause; CSR write dropped.
REQ-047 MRET after REQ-045 -> MIE=1, mepc_out=0x40.
REQ-048 WFI with mie=0x80, irq_timer raised after 5 cycles -> stall 5+1 cycles, then RUN; CSRRS 0xF14 rs1=1 -> illegal_csr=1.
REQ-049 CSR_COUNTERS_EN: write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF -> next cycle reads 0; undefined: 0xB00 illegal.

Source files
------------

// File: rtl/csr_trap_unit_pkg.sv
// ---------------------------------------------------------------------------
// Common -- shared definitions for the machine-mode CSR / trap unit.
//
// Contents:
//   * CSR address constants (machine-mode subset plus optional counters)
//   * csr_op_e    : CSR instruction flavour (none / write / set / clear)
//   * cause codes : interrupt causes written to mcause
//   * bit indices : mstatus.MIE/MPIE, mie/mip timer and external bits
//   * trap_state_e: RUN / WFI core state
//   * csr_apply() : computes the post-instruction value of a CSR
// ---------------------------------------------------------------------------
package Common;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // 64-bit counters, low and high halves
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  // Interrupt causes (bit 31 marks an interrupt)
  localparam logic [31:0] CAUSE_M_TIMER_IRQ = 32'h8000_0007;
  localparam logic [31:0] CAUSE_M_EXT_IRQ   = 32'h8000_000B;

  // mstatus bit positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // mie / mip bit positions (shared layout)
  localparam int MIE_MTIE_BIT = 7;
  localparam int MIE_MEIE_BIT = 11;

  // RV32I, machine mode only
  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_WFI = 1'b1
  } trap_state_e;

  // New CSR value for a given operation on the old value.
  function automatic logic [31:0] csr_apply(input csr_op_e op,
                                            input logic [31:0] old_value,
                                            input logic [31:0] operand);
    logic [31:0] result;
    case (op)
      CSR_WRITE: result = operand;
      CSR_SET:   result = old_value | operand;
      CSR_CLEAR: result = old_value & ~operand;
      default:   result = old_value;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// ---------------------------------------------------------------------------
// csr_counter64 -- 64-bit CSR counter with 32-bit half-word write access.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset, clears the count
//   inc    in   increment this cycle
//   wr_lo  in   write wdata to count[31:0]
//   wr_hi  in   write wdata to count[63:32]
//   wdata  in   32-bit write data
//   count  out  current 64-bit value
//
// A write in a cycle suppresses that cycle's increment; the count wraps
// from all-ones to zero.
// ---------------------------------------------------------------------------
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata;
      if (wr_hi) count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// ---------------------------------------------------------------------------
// csr_trap_unit -- machine-mode CSR file, trap entry/return and WFI control.
//
// Parameters:
//   MTVEC_RESET  reset value of mtvec
//   HART_ID      value returned by mhartid
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   instr_valid         an instruction retires this cycle
//   instr_pc            its PC
//   csr_op, csr_source  CSR operation and operand select (0 rs1_data, 1 uimm)
//   csr_addr, rs1_data, uimm
//   exc_request/cause   synchronous exception of that instruction
//   exc_ret, wfi        MRET / WFI
//   irq_timer, irq_ext  level interrupt requests (synchronous)
//   csr_rdata           old value of the addressed CSR (combinational)
//   illegal_csr         unimplemented address or write to a read-only CSR
//   trap_taken          redirect PC to trap_vector this cycle
//   trap_vector         mtvec
//   mepc_out            MRET target
//   stall               core held in WFI
//
// Build option: define CSR_COUNTERS_EN to add mcycle/minstret (0xB00/0xB80,
// 0xB02/0xB82). Without it those addresses are illegal.
// ---------------------------------------------------------------------------
module csr_trap_unit
  import Common::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int unsigned HART_ID     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr_pc,
  input  logic [1:0]  csr_op,
  input  logic        csr_source,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  uimm,
  input  logic        exc_request,
  input  logic [31:0] exc_cause,
  input  logic        exc_ret,
  input  logic        wfi,
  input  logic        irq_timer,
  input  logic        irq_ext,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  output logic        trap_taken,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        stall
);

  localparam logic [31:0] HART_ID_VALUE = 32'(HART_ID);

  // Architectural state
  logic        st_mie;
  logic        st_mpie;
  logic        mie_mtie;
  logic        mie_meie;
  logic        mip_mtip;
  logic        mip_meip;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;

  trap_state_e state_q;
  trap_state_e state_d;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;
`endif

  // Instruction decode
  csr_op_e     op;
  logic [31:0] operand;
  logic        no_write;
  logic        csr_access;

  assign op         = csr_op_e'(csr_op);
  assign operand    = csr_source ? {27'd0, uimm} : rs1_data;
  // Set/clear with a zero operand is a pure read: no write, no read-only fault.
  assign no_write   = (op == CSR_NONE) ||
                      (((op == CSR_SET) || (op == CSR_CLEAR)) && (operand == '0));
  assign csr_access = instr_valid && (op != CSR_NONE);

  // Read views of the packed registers
  logic [31:0] mstatus_value;
  logic [31:0] mie_value;
  logic [31:0] mip_value;

  always_comb begin
    mstatus_value                   = '0;
    mstatus_value[12:11]            = 2'b11;  // MPP: machine mode only
    mstatus_value[MSTATUS_MIE_BIT]  = st_mie;
    mstatus_value[MSTATUS_MPIE_BIT] = st_mpie;
    mie_value                       = '0;
    mie_value[MIE_MTIE_BIT]         = mie_mtie;
    mie_value[MIE_MEIE_BIT]         = mie_meie;
    mip_value                       = '0;
    mip_value[MIE_MTIE_BIT]         = mip_mtip;
    mip_value[MIE_MEIE_BIT]         = mip_meip;
  end

  // Address decode and read mux
  logic [31:0] rdata_raw;
  logic        addr_valid;
  logic        read_only;

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    rdata_raw  = '0;
    addr_valid = 1'b1;
    read_only  = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:   rdata_raw = mstatus_value;
      CSR_MISA:      rdata_raw = MISA_VALUE;     // writes accepted, ignored
      CSR_MIE:       rdata_raw = mie_value;
      CSR_MTVEC:     rdata_raw = mtvec;
      CSR_MSCRATCH:  rdata_raw = mscratch;
      CSR_MEPC:      rdata_raw = mepc;
      CSR_MCAUSE:    rdata_raw = mcause;
      CSR_MIP: begin
        rdata_raw = mip_value;
        read_only = 1'b1;
      end
      CSR_MVENDORID: read_only = 1'b1;
      CSR_MHARTID: begin
        rdata_raw = HART_ID_VALUE;
        read_only = 1'b1;
      end
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    rdata_raw = mcycle[31:0];
      CSR_MCYCLEH:   rdata_raw = mcycle[63:32];
      CSR_MINSTRET:  rdata_raw = minstret[31:0];
      CSR_MINSTRETH: rdata_raw = minstret[63:32];
`endif
      default:       addr_valid = 1'b0;
    endcase
  end

  // Interrupt and trap decision
  logic        irq_ext_active;
  logic        irq_tmr_active;
  logic        irq_any;
  logic        irq_pending;
  logic        trap;
  logic [31:0] trap_cause;
  logic        csr_we;
  logic        do_mret;
  logic [31:0] csr_wdata;
  logic        illegal;

  assign irq_ext_active = mip_meip && mie_meie;
  assign irq_tmr_active = mip_mtip && mie_mtie;
  assign irq_any        = irq_ext_active || irq_tmr_active;
  assign irq_pending    = st_mie && irq_any;

  // An interrupt preempts the instruction's own exception, CSR write and MRET.
  assign trap       = instr_valid && (irq_pending || exc_request);
  assign trap_cause = irq_pending ? (irq_ext_active ? CAUSE_M_EXT_IRQ : CAUSE_M_TIMER_IRQ)
                                  : exc_cause;

  assign illegal   = csr_access && (!addr_valid || (read_only && !no_write));
  assign csr_we    = csr_access && !no_write && addr_valid && !read_only && !trap;
  assign do_mret   = instr_valid && exc_ret && !trap;
  assign csr_wdata = csr_apply(op, rdata_raw, operand);

  // RUN/WFI state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: if (instr_valid && wfi && !trap) state_d = ST_WFI;
      // Wake-up ignores mstatus.MIE; the trap itself waits for MIE.
      ST_WFI: if (irq_any) state_d = ST_RUN;
    endcase
  end

  // CSR and trap state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mie_mtie <= 1'b0;
      mie_meie <= 1'b0;
      mip_mtip <= 1'b0;
      mip_meip <= 1'b0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      mip_mtip <= irq_timer;
      mip_meip <= irq_ext;

      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mie  <= csr_wdata[MSTATUS_MIE_BIT];
            st_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
          end
          CSR_MIE: begin
            mie_mtie <= csr_wdata[MIE_MTIE_BIT];
            mie_meie <= csr_wdata[MIE_MEIE_BIT];
          end
          CSR_MTVEC:    mtvec    <= {csr_wdata[31:2], 2'b00};
          CSR_MSCRATCH: mscratch <= csr_wdata;
          CSR_MEPC:     mepc     <= {csr_wdata[31:2], 2'b00};
          CSR_MCAUSE:   mcause   <= csr_wdata;
          default: ;
        endcase
      end

      // Trap entry and MRET override a same-cycle mstatus write.
      if (trap) begin
        mepc    <= instr_pc;
        mcause  <= trap_cause;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (do_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (csr_we && (csr_addr == CSR_MCYCLE)),
    .wr_hi (csr_we && (csr_addr == CSR_MCYCLEH)),
    .wdata (csr_wdata),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_valid && !trap),
    .wr_lo (csr_we && (csr_addr == CSR_MINSTRET)),
    .wr_hi (csr_we && (csr_addr == CSR_MINSTRETH)),
    .wdata (csr_wdata),
    .count (minstret)
  );
`endif

  // Outputs are forced quiet while reset is held.
  assign csr_rdata   = rst ? '0 : rdata_raw;
  assign illegal_csr = !rst && illegal;
  assign trap_taken  = !rst && trap;
  assign trap_vector = mtvec;
  assign mepc_out    = mepc;
  assign stall       = (state_q == ST_WFI);

endmodule

// File: tb/tb_csr_trap_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_trap_unit -- directed scoreboard bench for csr_trap_unit.
// Each stimulus step pushes its hand-computed expected outputs into a queue;
// a monitor pops and compares on the falling edge of every issued cycle.
// ---------------------------------------------------------------------------
module tb_csr_trap_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
  localparam int unsigned HART      = 3;
  localparam logic [31:0] HART_VAL  = 32'h0000_0003;
  localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

  localparam logic [1:0] OP_N = 2'd0;
  localparam logic [1:0] OP_W = 2'd1;
  localparam logic [1:0] OP_S = 2'd2;
  localparam logic [1:0] OP_C = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [1:0]  csr_op;
  logic        csr_source;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  uimm;
  logic        exc_request;
  logic [31:0] exc_cause;
  logic        exc_ret;
  logic        wfi;
  logic        irq_timer;
  logic        irq_ext;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic        trap_taken;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;
  logic        stall;

  always #5 clk = ~clk;

  csr_trap_unit #(
    .MTVEC_RESET (MTVEC_RST),
    .HART_ID     (HART)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .csr_op      (csr_op),
    .csr_source  (csr_source),
    .csr_addr    (csr_addr),
    .rs1_data    (rs1_data),
    .uimm        (uimm),
    .exc_request (exc_request),
    .exc_cause   (exc_cause),
    .exc_ret     (exc_ret),
    .wfi         (wfi),
    .irq_timer   (irq_timer),
    .irq_ext     (irq_ext),
    .csr_rdata   (csr_rdata),
    .illegal_csr (illegal_csr),
    .trap_taken  (trap_taken),
    .trap_vector (trap_vector),
    .mepc_out    (mepc_out),
    .stall       (stall)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        illegal;
    logic        trap;
    logic [31:0] tvec;
    logic [31:0] mepc;
    logic        stall;
  } exp_t;

  exp_t        exp_q[$];
  logic        tb_issue = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Architectural expectations that persist across steps
  logic [31:0] exp_tvec;
  logic [31:0] exp_mepc;
  logic        exp_stall;

  task automatic check(input string name, input string field,
                       input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, actual, expected);
    end
  endtask

  // Monitor: compares every issued cycle against the scoreboard head.
  always @(negedge clk) begin
    if (tb_issue) begin
      if (exp_q.size() == 0) begin
        check("scoreboard", "empty_on_issue", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, "csr_rdata",   csr_rdata,          e.rdata);
        check(e.name, "illegal_csr", {31'd0, illegal_csr}, {31'd0, e.illegal});
        check(e.name, "trap_taken",  {31'd0, trap_taken},  {31'd0, e.trap});
        check(e.name, "trap_vector", trap_vector,        e.tvec);
        check(e.name, "mepc_out",    mepc_out,           e.mepc);
        check(e.name, "stall",       {31'd0, stall},       {31'd0, e.stall});
      end
    end
  end

  // One instruction cycle: drive, record expectation, advance past the edge.
  task automatic step(input string name, input logic v, input logic [1:0] op,
                      input logic [11:0] addr, input logic [31:0] rs1,
                      input logic [31:0] e_rdata, input logic e_ill, input logic e_trap);
    exp_t e;
    instr_valid = v;
    csr_op      = op;
    csr_addr    = addr;
    rs1_data    = rs1;
    e.name      = name;
    e.rdata     = e_rdata;
    e.illegal   = e_ill;
    e.trap      = e_trap;
    e.tvec      = exp_tvec;
    e.mepc      = exp_mepc;
    e.stall     = exp_stall;
    exp_q.push_back(e);
    tb_issue = 1'b1;
    @(posedge clk);
    #1;
    tb_issue    = 1'b0;
    instr_valid = 1'b0;
    csr_op      = OP_N;
    csr_source  = 1'b0;
    uimm        = '0;
    rs1_data    = '0;
    exc_request = 1'b0;
    exc_ret     = 1'b0;
    wfi         = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_pc = 32'h100; csr_op = OP_N;
    csr_source = 1'b0; csr_addr = '0; rs1_data = '0; uimm = '0;
    exc_request = 1'b0; exc_cause = '0; exc_ret = 1'b0; wfi = 1'b0;
    irq_timer = 1'b0; irq_ext = 1'b0;
    exp_tvec = MTVEC_RST; exp_mepc = '0; exp_stall = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    // Outputs quiet during reset even with an excepting instruction presented
    exc_request = 1'b1; exc_cause = 32'd2;
    step("rst_outputs", 1, OP_S, 12'h300, 0, 32'h0, 0, 0);
    rst = 1'b0;

    step("mstatus_reset", 1, OP_S, 12'h300, 0, 32'h0000_1800, 0, 0);
    step("mtvec_reset",   1, OP_S, 12'h305, 0, MTVEC_RST, 0, 0);
    step("mhartid",       1, OP_S, 12'hF14, 0, HART_VAL, 0, 0);
    step("misa",          1, OP_S, 12'h301, 0, 32'h4000_0100, 0, 0);

    step("csrrw_mtvec",   1, OP_W, 12'h305, 32'h8000_0103, MTVEC_RST, 0, 0);
    exp_tvec = 32'h8000_0100;
    step("mtvec_aligned", 1, OP_S, 12'h305, 0, 32'h8000_0100, 0, 0);

    step("mscratch_w",    1, OP_W, 12'h340, 32'h1234_5678, 32'h0, 0, 0);
    csr_source = 1'b1; uimm = 5'h11;
    step("mscratch_si",   1, OP_S, 12'h340, 0, 32'h1234_5678, 0, 0);
    step("mscratch_c",    1, OP_C, 12'h340, 32'h78, 32'h1234_5679, 0, 0);
    step("mscratch_rd",   1, OP_S, 12'h340, 0, 32'h1234_5601, 0, 0);

    step("bad_addr",      1, OP_W, 12'h7C0, 32'hFFFF, 32'h0, 1, 0);
    step("ro_write",      1, OP_S, 12'hF14, 32'h1, HART_VAL, 1, 0);
    step("ro_read",       1, OP_S, 12'hF14, 0, HART_VAL, 0, 0);
    step("ro_clear_zero", 1, OP_C, 12'hF11, 0, 32'h0, 0, 0);
    step("mip_write",     1, OP_W, 12'h344, 32'h880, 32'h0, 1, 0);

    step("mepc_w",        1, OP_W, 12'h341, 32'h203, 32'h0, 0, 0);
    exp_mepc = 32'h200;

    // External interrupt entry, preempting an exception and a CSR write
    step("mie_w",         1, OP_W, 12'h304, 32'h800, 32'h0, 0, 0);
    irq_ext = 1'b1;
    idle(1);
    step("mip_ext",       1, OP_S, 12'h344, 0, 32'h800, 0, 0);
    step("mstatus_mie",   1, OP_S, 12'h300, 32'h8, 32'h0000_1800, 0, 0);
    instr_pc = 32'h40; exc_request = 1'b1; exc_cause = 32'd2;
    step("irq_ext_trap",  1, OP_W, 12'h340, 32'hDEAD, 32'h1234_5601, 0, 1);
    exp_mepc = 32'h40;
    irq_ext = 1'b0;
    idle(1);
    instr_pc = 32'h44;
    step("mcause_ext",    1, OP_S, 12'h342, 0, CAUSE_EXT, 0, 0);
    step("mstatus_trap",  1, OP_S, 12'h300, 0, 32'h0000_1880, 0, 0);
    step("mscratch_kept", 1, OP_S, 12'h340, 0, 32'h1234_5601, 0, 0);
    step("mepc_trap",     1, OP_S, 12'h341, 0, 32'h40, 0, 0);

    exc_ret = 1'b1;
    step("mret",          1, OP_N, 12'h341, 0, 32'h40, 0, 0);
    step("mstatus_mret",  1, OP_S, 12'h300, 0, 32'h0000_1888, 0, 0);

    // Not retiring: no trap, no write
    exc_request = 1'b1; exc_cause = 32'd5;
    step("no_valid",      0, OP_W, 12'h340, 32'hFFFF, 32'h1234_5601, 0, 0);
    step("no_valid_kept", 1, OP_S, 12'h340, 0, 32'h1234_5601, 0, 0);

    // Priority: external over timer, then timer alone
    step("mie_set_mtie",  1, OP_S, 12'h304, 32'h80, 32'h800, 0, 0);
    irq_timer = 1'b1; irq_ext = 1'b1;
    idle(1);
    instr_pc = 32'h80;
    step("irq_both",      1, OP_S, 12'h300, 0, 32'h0000_1888, 0, 1);
    exp_mepc = 32'h80;
    irq_ext = 1'b0;
    idle(1);
    step("mcause_prio",   1, OP_S, 12'h342, 0, CAUSE_EXT, 0, 0);
    exc_ret = 1'b1;
    step("mret2",         1, OP_N, 12'h342, 0, CAUSE_EXT, 0, 0);
    instr_pc = 32'h90;
    step("irq_tmr_trap",  1, OP_S, 12'h342, 0, CAUSE_EXT, 0, 1);
    exp_mepc = 32'h90;
    irq_timer = 1'b0;
    idle(1);
    step("mcause_timer",  1, OP_S, 12'h342, 0, CAUSE_TMR, 0, 0);

    // WFI with MIE=0: wake on timer, no trap
    step("mie_tmr_only",  1, OP_W, 12'h304, 32'h80, 32'h880, 0, 0);
    wfi = 1'b1;
    step("wfi",           1, OP_N, 12'h304, 0, 32'h80, 0, 0);
    exp_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) irq_timer = 1'b1;
      step("wfi_stall",   0, OP_N, 12'h304, 0, 32'h80, 0, 0);
    end
    step("wfi_stall_6",   0, OP_N, 12'h304, 0, 32'h80, 0, 0);
    exp_stall = 1'b0;
    step("wfi_woke_ro",   1, OP_S, 12'hF14, 32'h1, HART_VAL, 1, 0);
    irq_timer = 1'b0;
    idle(1);

    // Reset while in WFI
    wfi = 1'b1;
    step("wfi2",          1, OP_N, 12'h300, 0, 32'h0000_1880, 0, 0);
    exp_stall = 1'b1;
    step("wfi2_stall",    0, OP_N, 12'h300, 0, 32'h0000_1880, 0, 0);
    rst = 1'b1;
    exp_stall = 1'b0; exp_tvec = MTVEC_RST; exp_mepc = '0;
    step("rst_in_wfi",    1, OP_S, 12'h300, 0, 32'h0, 0, 0);
    rst = 1'b0;

`ifdef CSR_COUNTERS_EN
    step("mcycle_w",      1, OP_W, 12'hB00, 32'hFFFF_FFFF, 32'h0, 0, 0);
    step("mcycleh_w",     1, OP_W, 12'hB80, 32'hFFFF_FFFF, 32'h0, 0, 0);
    step("mcycle_max",    1, OP_S, 12'hB00, 0, 32'hFFFF_FFFF, 0, 0);
    step("mcycleh_wrap",  1, OP_S, 12'hB80, 0, 32'h0, 0, 0);
    step("mcycle_next",   1, OP_S, 12'hB00, 0, 32'h1, 0, 0);
    step("minstret",      1, OP_S, 12'hB02, 0, 32'h5, 0, 0);
`else
    step("mcycle_undef",  1, OP_S, 12'hB00, 0, 32'h0, 1, 0);
    step("minstreth_undef", 1, OP_S, 12'hB82, 0, 32'h0, 1, 0);
`endif
    step("mstatus_rst2",  1, OP_S, 12'h300, 0, 32'h0000_1800, 0, 0);
    step("mtvec_rst2",    1, OP_S, 12'h305, 0, MTVEC_RST, 0, 0);

    idle(1);
    check("scoreboard", "pending", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
